ps2_host_tx: RTL

Host-to-device PS/2 transmitter for the keyboard port: the transmit half of the keyboard link. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the keyboard using the PS/2 request-to-send sequence. It sits in the decoder CPLD beside the PS/2 scan-code receiver and shares the open-drain KB_CLK/KB_DATA pins with it. The top level converts the two active-high pull-low outputs into pin drivers: pin = LO ? 0 : Z.

---
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard using the
// request-to-send sequence on shared open-drain clock/data lines (active-high pull-low outputs).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 262143
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    input  logic       kb_clk_i,
    input  logic       kb_data_i,
    output logic       kb_clk_lo_o,
    output logic       kb_data_lo_o
);

    localparam int CNT_W = 18;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_WAITIDLE = 3'd5;
    localparam logic [2:0] ST_FINISH   = 3'd6;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [9:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_lo_q, clk_lo_d;
    logic             data_lo_q, data_lo_d;
    logic [2:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             fe_s;
    logic             timeout_s;

    // Bits [1:0] are the two-stage synchronizer; bit 2 holds the previous synchronized clock.
    assign fe_s      = clk_sync_q[2] & ~clk_sync_q[1];
    assign timeout_s = (cnt_q == TO_LAST);

    // Next-state and output decode for the transmit sequence
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        clk_lo_d  = clk_lo_q;
        data_lo_d = data_lo_q;
        case (state_q)
            ST_IDLE: begin
                clk_lo_d  = 1'b0;
                data_lo_d = 1'b0;
                if (tx_start_i) begin
                    state_d  = ST_INHIBIT;
                    shift_d  = {1'b1, odd_parity(tx_data_i), tx_data_i};
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    clk_lo_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d   = ST_START;
                    data_lo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end
            ST_START: begin
                state_d  = ST_SHIFT;
                clk_lo_d = 1'b0;
                cnt_d    = '0;
                idx_d    = 4'd0;
            end
            ST_SHIFT, ST_ACK, ST_WAITIDLE: begin
                if (timeout_s) begin
                    state_d   = ST_FINISH;
                    err_d     = 1'b1;
                    clk_lo_d  = 1'b0;
                    data_lo_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                    if (state_q == ST_SHIFT) begin
                        if (fe_s) begin
                            data_lo_d = ~shift_q[0];
                            shift_d   = {1'b0, shift_q[9:1]};
                            idx_d     = idx_q + 4'd1;
                            if (idx_q == 4'd9) begin
                                state_d = ST_ACK;
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else if (state_q == ST_ACK) begin
                        if (fe_s) begin
                            err_d   = data_sync_q[1];
                            state_d = ST_WAITIDLE;
                        end else begin
                            state_d = ST_ACK;
                        end
                    end else begin
                        if (clk_sync_q[1] && data_sync_q[1]) begin
                            state_d = ST_FINISH;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_WAITIDLE;
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                clk_lo_d  = 1'b0;
                data_lo_d = 1'b0;
            end
        endcase
    end

    // Pin synchronizers; reset to the released (high) level so no false edge appears
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], kb_clk_i};
            data_sync_q <= {data_sync_q[0], kb_data_i};
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            shift_q   <= 10'd0;
            cnt_q     <= '0;
            idx_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_lo_q  <= 1'b0;
            data_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            clk_lo_q  <= clk_lo_d;
            data_lo_q <= data_lo_d;
        end
    end

    assign tx_busy_o    = busy_q;
    assign tx_done_o    = done_q;
    assign tx_err_o     = err_q;
    assign kb_clk_lo_o  = clk_lo_q;
    assign kb_data_lo_o = data_lo_q;

endmodule
